game_engine: RTL and testbench
==============================

# game_engine

Parametrised N×N, K-in-a-row two-player game core, the successor to the fixed 3×3 game-state logic. It sits between the keypad decoder and the display and result modules. It accepts one cell index per move, maintains the board and turn, and checks for a win by scanning only the lines through the last move. Win checking is sequential and fixed-latency, and a win always takes priority over a draw on the last move.

## Interface
- `N`, 3: board side; cells are indexed row-major, `i = r*N + c`.
- `K`, 3: run length needed to win; 2 ≤ K ≤ N.
- `IDX_W`, `$clog2(N*N)`: width of a cell index.
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: clear the board and begin a new game with X to move.
- `key_valid`  in  1  one-cycle strobe: `key_data` holds a move.
- `key_data`  in  IDX_W  cell index, 0-based.
- `board`  out  2*N*N  cell i occupies bits [2i+1:2i]; 00 = empty, 01 = X, 10 = O.
- `IsTurnO`  out  1  0 = X to move, 1 = O to move.
- `result`  out  2  00 = in progress, 01 = X wins, 10 = O wins, 11 = draw.
- `move_ok`  out  1  one-cycle pulse: move accepted.
- `move_err`  out  1  one-cycle pulse: move rejected (index ≥ N*N, or cell occupied).
- `busy`  out  1  high while the win check runs.

## Operation
- **States:** IDLE, WAIT, CHECK, DONE.
- **Reset values:** state IDLE; `board`=0, `IsTurnO`=0, `result`=00, `move_ok`=`move_err`=`busy`=0; move counter 0.
- **start in any state:** clears board, turn, result and counter, then enters WAIT. `start` beats a same-cycle `key_valid`, which is dropped. `start` during CHECK aborts the check.
- **IDLE / DONE:** `key_valid` is ignored; no `move_ok` or `move_err`.
- **WAIT, legal key:** writes the mover's code to the cell, increments the counter, pulses `move_ok`, latches the cell's row/column, and enters CHECK.
- **WAIT, illegal key:** pulses `move_err`; board and turn are unchanged and the state stays WAIT.
- **CHECK scan:**
  - Directions d = 0..3 are horizontal, vertical, diagonal (↘) and anti-diagonal (↙).
  - For each d, offset s runs from −(K−1) to +(K−1). That is 2K−1 steps per direction, one cell per cycle.
  - A run counter counts consecutive mover cells. It resets at the start of each direction, on any non-mover cell, and on any position outside the board.
  - Out-of-board is judged by row/col bounds (0..N−1), never by flat index, so there is no row wraparound.
  - A run count reaching K sets a sticky win flag.
  - There is no early exit: CHECK always lasts L = 4*(2K−1) cycles.
- **End of CHECK, in priority order:**
  - Win: `result` = 01 (X) or 10 (O), go to DONE.
  - Else counter = N*N: `result` = 11, go to DONE.
  - Else: toggle `IsTurnO`, go to WAIT.
- **Widths:** row/col counters are `$clog2(N)+1` bits signed, so off-board offsets stay representable. The move counter is `$clog2(N*N+1)` bits.

## Timing
- Key accepted at edge t:
  - `board` and `move_ok` are valid after edge t+1.
  - `busy` is high for L cycles.
  - `result`, `IsTurnO` and the next state update L cycles after `move_ok`. For N=K=3, L = 20.
- `move_err` is asserted one cycle after the strobe.
- `key_valid` while `busy` is ignored with no pulse; the upstream debouncer must hold off.
- All outputs are registered. Reset mid-CHECK returns immediately to the reset values.

## Structure
- **`game_pkg`:** cell codes (EMPTY/X/O), result codes, state enum, and the direction delta table (dr, dc) for d = 0..3.
- **Sub-module `game_line_check`:** takes row, col, d, s and the board; returns "cell is in range and equals mover". The engine owns the d/s counters and the run counter.
- Expected size is about 200 lines of RTL.

## Test plan
1. **Reset behaviour:** assert `rst`, then apply `key_valid` with `key_data`=4 before any `start` → board 0, `result` 00, `IsTurnO` 0, no pulses.
2. **X row win (N=K=3):** `start`; play X0, O3, X1, O4, X2 → `result`=01 exactly 20 cycles after the last `move_ok`. A further key 5 is ignored.
3. **Occupied cell:** X4 then O4 → `move_err` one cycle after the strobe; `IsTurnO` stays 1 and board bits [9:8] stay 01.
4. **No row wraparound:** X2, O0, X3, O8, X4 → `result` 00, `IsTurnO`=1.
5. **Draw versus last-move win:**
   - X0, O1, X2, O4, X3, O5, X7, O6, X8 → 11.
   - X0, O1, X2, O4, X3, O5, X7, O8, X6 → 01 (win beats full board).
6. **Larger board and abort (N=5, K=4):**
   - X at 6, 12, 18, 24, with O at 0, 1, 2 → 01 after L = 28 cycles.
   - Then `rst` asserted mid-CHECK on a new game → all outputs return to reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Shared cell/result codes, FSM states and the scan direction table for the
// N x N, K-in-a-row game core.
package game_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_X    = 2'b01;
  localparam logic [1:0] RES_O    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // d = 0..3: horizontal, vertical, diagonal (down-right), anti-diagonal (down-left)
  localparam int DIR_DR [4] = '{0, 1, 1, 1};
  localparam int DIR_DC [4] = '{1, 0, 1, -1};

endpackage

// File: rtl/game_line_check.sv
// Looks up the cell at offset s along direction d from (row, col) and reports
// whether it lies on the board and holds the mover's mark.
module game_line_check
  import game_pkg::*;
#(
  parameter int N     = 3,
  parameter int RC_W  = $clog2(N) + 1,
  parameter int OFF_W = 3
) (
  input  logic signed [RC_W-1:0]  i_row,
  input  logic signed [RC_W-1:0]  i_col,
  input  logic        [1:0]       i_dir,
  input  logic signed [OFF_W-1:0] i_off,
  input  logic        [2*N*N-1:0] i_board,
  input  logic        [1:0]       i_mover,
  output logic                    o_hit
);

  int         w_r;
  int         w_c;
  int         w_idx;
  logic       w_in_range;
  logic [1:0] w_cell;

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    w_cell     = CELL_EMPTY;
    w_r        = int'(i_row) + DIR_DR[i_dir] * int'(i_off);
    w_c        = int'(i_col) + DIR_DC[i_dir] * int'(i_off);
    // Bounds on row and column separately, so a run never wraps onto the next row.
    w_in_range = (w_r >= 0) && (w_r < N) && (w_c >= 0) && (w_c < N);
    w_idx      = w_r * N + w_c;
    for (int i = 0; i < N*N; i++) begin
      if (w_in_range && (w_idx == i)) w_cell = i_board[2*i +: 2];
    end
    o_hit = w_in_range && (w_cell == i_mover);
  end

endmodule

// File: rtl/game_engine.sv
// N x N, K-in-a-row game core: keeps board, turn and move count, and runs a
// fixed-latency win scan through the last move.
module game_engine
  import game_pkg::*;
#(
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int IDX_W = $clog2(N*N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_valid,
  input  logic [IDX_W-1:0] key_data,
  output logic [2*N*N-1:0] board,
  output logic             IsTurnO,
  output logic [1:0]       result,
  output logic             move_ok,
  output logic             move_err,
  output logic             busy
);

  localparam int RC_W  = $clog2(N) + 1;
  localparam int OFF_W = $clog2(K) + 1;
  localparam int CNT_W = $clog2(N*N + 1);
  localparam int RUN_W = $clog2(K + 1);

  localparam logic signed [OFF_W-1:0] OFF_FIRST = OFF_W'(1 - K);
  localparam logic signed [OFF_W-1:0] OFF_LAST  = OFF_W'(K - 1);
  localparam logic        [CNT_W-1:0] CELLS     = CNT_W'(N * N);
  localparam logic        [RUN_W-1:0] RUN_WIN   = RUN_W'(K);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2*N*N-1:0]        r_board;
  logic                    r_turn_o;
  logic [1:0]              r_result;
  logic                    r_move_ok;
  logic                    r_move_err;
  logic                    r_busy;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [RC_W-1:0]  r_row;
  logic signed [RC_W-1:0]  r_col;
  logic [1:0]              r_dir;
  logic signed [OFF_W-1:0] r_off;
  logic [RUN_W-1:0]        r_run;
  logic                    r_win;

  logic [1:0]       w_mover;
  logic             w_key_empty;
  logic             w_hit;
  logic             w_dir_end;
  logic             w_last_step;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_win_nxt;
  logic             w_accept;
  logic             w_reject;

  game_line_check #(
    .N    (N),
    .RC_W (RC_W),
    .OFF_W(OFF_W)
  ) u_line_check (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_dir  (r_dir),
    .i_off  (r_off),
    .i_board(r_board),
    .i_mover(w_mover),
    .o_hit  (w_hit)
  );

  // Key legality and scan bookkeeping; out-of-range indices never match a cell.
  always_comb begin
    w_mover     = r_turn_o ? CELL_O : CELL_X;
    w_key_empty = 1'b0;
    for (int i = 0; i < N*N; i++) begin
      if (int'(key_data) == i) w_key_empty = (r_board[2*i +: 2] == CELL_EMPTY);
    end
    w_dir_end   = (r_off == OFF_LAST);
    w_last_step = w_dir_end && (r_dir == 2'd3);
    if (!w_hit)                w_run_nxt = '0;
    else if (r_run == RUN_WIN) w_run_nxt = r_run;
    else                       w_run_nxt = r_run + RUN_W'(1);
    w_win_nxt = r_win || (w_run_nxt == RUN_WIN);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    if (start) begin
      w_state_nxt = ST_WAIT;
    end else begin
      unique case (r_state)
        ST_WAIT: begin
          if (key_valid) begin
            if (w_key_empty) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_CHECK;
            end else begin
              w_reject = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (w_last_step)
            w_state_nxt = (w_win_nxt || (r_cnt == CELLS)) ? ST_DONE : ST_WAIT;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the board is a flat register vector, not a RAM, so it is cleared by reset like any flop.
      r_board    <= '0;
      r_turn_o   <= 1'b0;
      r_result   <= RES_NONE;
      r_move_ok  <= 1'b0;
      r_move_err <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_dir      <= '0;
      r_off      <= OFF_FIRST;
      r_run      <= '0;
      r_win      <= 1'b0;
    end else begin
      r_move_ok  <= w_accept;
      r_move_err <= w_reject;
      r_busy     <= (w_state_nxt == ST_CHECK);
      if (start) begin
        r_board  <= '0;
        r_turn_o <= 1'b0;
        r_result <= RES_NONE;
        r_cnt    <= '0;
      end else if (w_accept) begin
        for (int i = 0; i < N*N; i++) begin
          if (int'(key_data) == i) r_board[2*i +: 2] <= w_mover;
        end
        r_cnt <= r_cnt + CNT_W'(1);
        r_row <= RC_W'(int'(key_data) / N);
        r_col <= RC_W'(int'(key_data) % N);
        r_dir <= '0;
        r_off <= OFF_FIRST;
        r_run <= '0;
        r_win <= 1'b0;
      end else if (r_state == ST_CHECK) begin
        r_win <= w_win_nxt;
        if (w_dir_end) begin
          r_dir <= r_dir + 2'd1;
          r_off <= OFF_FIRST;
          r_run <= '0;
        end else begin
          r_off <= r_off + OFF_W'(1);
          r_run <= w_run_nxt;
        end
        // A win on the final move outranks the full-board draw.
        if (w_last_step) begin
          if (w_win_nxt)           r_result <= r_turn_o ? RES_O : RES_X;
          else if (r_cnt == CELLS) r_result <= RES_DRAW;
          else                     r_turn_o <= ~r_turn_o;
        end
      end
    end
  end

  assign board    = r_board;
  assign IsTurnO  = r_turn_o;
  assign result   = r_result;
  assign move_ok  = r_move_ok;
  assign move_err = r_move_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_game_engine.sv
// Bench for game_engine: 3x3/K=3 and 5x5/K=4 instances, table-driven games,
// hand-written corner sequences and random games checked against a board model.
module tb_game_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        key_valid;
  logic        sel5;
  logic [4:0]  key_data;

  logic [17:0] board3;
  logic [49:0] board5;
  logic        turn3, turn5, ok3, ok5, err3, err5, busy3, busy5;
  logic [1:0]  res3, res5;

  logic [49:0] board_s;
  logic        turn_s, ok_s, err_s, busy_s;
  logic [1:0]  result_s;

  int errors = 0;
  int checks = 0;

  // Reference model of the selected instance: 0 empty, 1 X, 2 O.
  int mb [25];
  int mn, mk, m_turn, m_res, m_cnt, m_phase;  // phase: 0 idle, 1 playing, 2 over

  typedef struct {
    bit         sel5;
    int         nmoves;
    int         keys [9];
    logic [1:0] exp_res;
    logic       exp_turn;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  game_engine #(.N(3), .K(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .start    (start & ~sel5),
    .key_valid(key_valid & ~sel5),
    .key_data (key_data[3:0]),
    .board    (board3),
    .IsTurnO  (turn3),
    .result   (res3),
    .move_ok  (ok3),
    .move_err (err3),
    .busy     (busy3)
  );

  game_engine #(.N(5), .K(4)) dut5 (
    .clk      (clk),
    .rst      (rst),
    .start    (start & sel5),
    .key_valid(key_valid & sel5),
    .key_data (key_data),
    .board    (board5),
    .IsTurnO  (turn5),
    .result   (res5),
    .move_ok  (ok5),
    .move_err (err5),
    .busy     (busy5)
  );

  always_comb begin
    board_s  = sel5 ? board5 : {32'b0, board3};
    turn_s   = sel5 ? turn5  : turn3;
    result_s = sel5 ? res5   : res3;
    ok_s     = sel5 ? ok5    : ok3;
    err_s    = sel5 ? err5   : err3;
    busy_s   = sel5 ? busy5  : busy3;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [49:0] model_board();
    logic [49:0] b;
    b = '0;
    for (int i = 0; i < mn*mn; i++) b[2*i +: 2] = 2'(mb[i]);
    return b;
  endfunction

  // Any K-long straight run of 'who' anywhere on the board.
  function automatic bit model_win(input int who);
    int dr, dc, rr, cc;
    bit all;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        for (int d = 0; d < 4; d++) begin
          dr  = (d == 0) ? 0 : 1;
          dc  = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
          all = 1'b1;
          for (int j = 0; j < mk; j++) begin
            rr = r + j*dr;
            cc = c + j*dc;
            if (rr < 0 || rr >= mn || cc < 0 || cc >= mn) all = 1'b0;
            else if (mb[rr*mn + cc] != who)              all = 1'b0;
          end
          if (all) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic set_sel(input bit s);
    sel5 = s;
    mn   = s ? 5 : 3;
    mk   = s ? 4 : 3;
  endtask

  task automatic model_new();
    for (int i = 0; i < 25; i++) mb[i] = 0;
    m_turn = 0; m_res = 0; m_cnt = 0; m_phase = 1;
  endtask

  task automatic new_game();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_new();
    check("start_board", board_s, 0);
    check("start_result", result_s, 0);
    check("start_turn", turn_s, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_s === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", busy_s, 0);
  endtask

  // One key strobe, checked against the model including exact scan latency.
  task automatic press(input int key);
    int exp_ok, exp_err, l;
    exp_ok  = 0;
    exp_err = 0;
    l       = 4 * (2*mk - 1);
    if (m_phase == 1) begin
      if (key >= mn*mn || mb[key] != 0) exp_err = 1;
      else                              exp_ok  = 1;
    end
    @(negedge clk); key_valid = 1'b1; key_data = key[4:0];
    @(negedge clk); key_valid = 1'b0;
    check("move_ok", ok_s, exp_ok);
    check("move_err", err_s, exp_err);
    if (exp_ok == 1) begin
      mb[key] = m_turn + 1;
      m_cnt++;
      check("board", board_s, model_board());
      check("busy_on", busy_s, 1);
      repeat (l - 1) @(negedge clk);
      check("busy_hold", busy_s, 1);
      check("result_hold", result_s, 0);
      @(negedge clk);
      check("busy_off", busy_s, 0);
      if (model_win(m_turn + 1)) begin
        m_res = m_turn + 1; m_phase = 2;
      end else if (m_cnt == mn*mn) begin
        m_res = 3; m_phase = 2;
      end else begin
        m_turn = 1 - m_turn;
      end
      check("result", result_s, m_res);
      check("turn", turn_s, m_turn);
    end else begin
      check("board_kept", board_s, model_board());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_data = '0;
    set_sel(1'b0);
    m_phase = 0;

    vecs[0] = '{1'b0, 5, '{0, 3, 1, 4, 2, 0, 0, 0, 0}, 2'b01, 1'b0};  // X top row
    vecs[1] = '{1'b0, 2, '{4, 4, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b1};  // occupied cell
    vecs[2] = '{1'b0, 5, '{2, 0, 3, 8, 4, 0, 0, 0, 0}, 2'b00, 1'b1};  // no row wrap
    vecs[3] = '{1'b0, 9, '{0, 1, 2, 4, 3, 5, 7, 6, 8}, 2'b11, 1'b0};  // draw
    vecs[4] = '{1'b0, 9, '{0, 1, 2, 4, 3, 5, 7, 8, 6}, 2'b01, 1'b0};  // win on full board
    vecs[5] = '{1'b1, 7, '{6, 0, 12, 1, 18, 2, 24, 0, 0}, 2'b01, 1'b0}; // 5x5 diagonal

    // Reset state; a key before any start is ignored.
    @(negedge clk); key_valid = 1'b1; key_data = 5'd4;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); key_valid = 1'b0;
    @(negedge clk);
    check("rst_board", board_s, 0);
    check("rst_result", result_s, 0);
    check("rst_turn", turn_s, 0);
    check("rst_pulses", {ok_s, err_s, busy_s}, 0);
    check("rst_board5", board5, 0);

    for (int v = 0; v < 6; v++) begin
      set_sel(vecs[v].sel5);
      new_game();
      for (int j = 0; j < vecs[v].nmoves; j++) press(vecs[v].keys[j]);
      check("tbl_result", result_s, vecs[v].exp_res);
      check("tbl_turn", turn_s, vecs[v].exp_turn);
    end

    // Row win, then a further key is ignored in DONE.
    set_sel(1'b0);
    new_game();
    press(0); press(3); press(1); press(4); press(2);
    check("row_win", result_s, 2'b01);
    press(5);
    check("done_cell5", board_s[11:10], 2'b00);

    // Occupied cell keeps X in cell 4 and O to move.
    new_game();
    press(4); press(4);
    check("occ_cell4", board_s[9:8], 2'b01);
    check("occ_turn", turn_s, 1);
    press(13);

    // Key while busy is dropped without a pulse.
    new_game();
    @(negedge clk); key_valid = 1'b1; key_data = 5'd4;
    @(negedge clk); key_valid = 1'b0;
    check("busy_acc", ok_s, 1);
    mb[4] = 1; m_cnt = 1;
    @(negedge clk); key_valid = 1'b1; key_data = 5'd0;
    @(negedge clk); key_valid = 1'b0;
    check("busy_ignored", {ok_s, err_s}, 0);
    wait_idle();
    m_turn = 1;
    check("busy_board", board_s, model_board());
    check("busy_turn", turn_s, 1);

    // start beats a same-cycle key.
    new_game();
    @(negedge clk); start = 1'b1; key_valid = 1'b1; key_data = 5'd0;
    @(negedge clk); start = 1'b0; key_valid = 1'b0;
    check("start_key_pulse", {ok_s, err_s, busy_s}, 0);
    check("start_key_board", board_s, 0);
    press(0);

    // start during CHECK aborts the scan and clears the game.
    new_game();
    press(4);
    @(negedge clk); key_valid = 1'b1; key_data = 5'd0;
    @(negedge clk); key_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_new();
    check("abort_busy", busy_s, 0);
    check("abort_board", board_s, 0);
    check("abort_state", {result_s, turn_s}, 0);
    press(8);
    check("abort_x_cell8", board_s[17:16], 2'b01);

    // Random games against the model, mostly 3x3 with some 5x5.
    for (int g = 0; g < 16; g++) begin
      set_sel((g % 4) == 3);
      new_game();
      for (int m = 0; m < 80 && m_phase == 1; m++)
        press(sel5 ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 15)));
    end

    // Reset in the middle of a 5x5 scan.
    set_sel(1'b1);
    new_game();
    @(negedge clk); key_valid = 1'b1; key_data = 5'd12;
    @(negedge clk); key_valid = 1'b0;
    check("midrst_acc", ok_s, 1);
    repeat (5) @(negedge clk);
    check("midrst_busy", busy_s, 1);
    rst = 1'b1;
    #1;
    check("midrst_board", board_s, 0);
    check("midrst_outs", {result_s, turn_s, ok_s, err_s, busy_s}, 0);
    @(negedge clk); rst = 1'b0;
    m_phase = 0;
    press(3);
    check("midrst_idle", board_s, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
